// File: rtl/rv16_fu_scheduler.sv
// In-order single-issue scheduler: one holding register feeds seven functional
// units, each tracked by a down-counting occupancy counter.
module rv16_fu_scheduler #(
    parameter int DATA    = 4,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_opcode,
    input  logic [DATA-1:0] in_rs1,
    input  logic [DATA-1:0] in_rs2,
    output logic [6:0]      fu_issue,
    output logic [DATA-1:0] fu_rs1,
    output logic [DATA-1:0] fu_rs2,
    output logic [6:0]      fu_done,
    output logic            err_opcode,
    output logic [7:0]      issue_cnt
);

    // state | meaning
    // EMPTY | holding register empty, in_ready high
    // HELD  | instruction waiting for its unit (or about to be dropped)
    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [3:0]      hold_op;
    logic [DATA-1:0] hold_rs1, hold_rs2;
    logic [3:0]      cnt [7];
    logic [6:0]      launch_vec;
    logic            launch, drop, accept;

    function automatic logic [3:0] lat_of(input int unit);
        case (unit)
            2:       return 4'(MUL_LAT);
            3:       return 4'(DIV_LAT);
            default: return 4'd1;
        endcase
    endfunction

    // A unit whose counter is at 1 finishes this cycle, so it may be relaunched now.
    always_comb begin
        launch_vec = '0;
        fu_done    = '0;
        for (int k = 0; k < 7; k++) begin
            launch_vec[k] = (state == HELD) && (hold_op == 4'(k)) && (cnt[k] <= 4'd1);
            fu_done[k]    = (cnt[k] == 4'd1);
        end
    end

    always_comb begin
        launch    = |launch_vec;
        drop      = (state == HELD) && (hold_op > 4'd6);
        in_ready  = (state == EMPTY) || launch;
        accept    = in_valid && in_ready;
        state_nxt = state;
        if (accept) begin
            state_nxt = HELD;
        end else if (launch || drop) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_op  <= '0;
            hold_rs1 <= '0;
            hold_rs2 <= '0;
        end else if (accept) begin
            hold_op  <= in_opcode;
            hold_rs1 <= in_rs1;
            hold_rs2 <= in_rs2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fu_issue   <= '0;
            fu_rs1     <= '0;
            fu_rs2     <= '0;
            err_opcode <= 1'b0;
            issue_cnt  <= '0;
        end else begin
            fu_issue   <= launch_vec;
            err_opcode <= drop;
            issue_cnt  <= issue_cnt + 8'(launch);
            if (launch) begin
                fu_rs1 <= hold_rs1;
                fu_rs2 <= hold_rs2;
            end
        end
    end

    // Reload on launch wins over the per-cycle decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 7; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 7; k++) begin
                if (launch_vec[k]) begin
                    cnt[k] <= lat_of(k);
                end else if (cnt[k] != 4'd0) begin
                    cnt[k] <= cnt[k] - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv16_fu_scheduler.sv
// Scoreboard bench: a timing model based on per-unit free times predicts issue,
// done and error events; a monitor compares them against the DUT each cycle.
module tb_rv16_fu_scheduler;
    localparam int DATA    = 4;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      in_opcode = '0;
    logic [DATA-1:0] in_rs1 = '0;
    logic [DATA-1:0] in_rs2 = '0;
    logic [6:0]      fu_issue;
    logic [DATA-1:0] fu_rs1;
    logic [DATA-1:0] fu_rs2;
    logic [6:0]      fu_done;
    logic            err_opcode;
    logic [7:0]      issue_cnt;

    rv16_fu_scheduler #(.DATA(DATA), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .fu_issue(fu_issue), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_done(fu_done),
        .err_opcode(err_opcode), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int t;
        int unit;
        int rs1;
        int rs2;
        int cnt;
    } iss_t;

    iss_t     q_iss[$];
    int       q_err[$];
    bit [6:0] done_map[int];

    bit m_held = 0;
    int m_op, m_rs1, m_rs2;
    int m_free[7];
    int m_cnt = 0;

    function automatic int lat(input int op);
        if (op == 2) return MUL_LAT;
        if (op == 3) return DIV_LAT;
        return 1;
    endfunction

    task automatic model_clear();
        m_held = 0;
        m_cnt  = 0;
        for (int k = 0; k < 7; k++) m_free[k] = 0;
        q_iss.delete();
        q_err.delete();
        done_map.delete();
    endtask

    // One clock of stimulus; the model decides what the next edge should do.
    task automatic step(input bit v, input int op, input int a, input int b, output bit acc);
        int  t;
        bit  launch, drop, exp_ready;
        @(negedge clk);
        in_valid  = v;
        in_opcode = 4'(op);
        in_rs1    = DATA'(a);
        in_rs2    = DATA'(b);
        #1;
        t = cyc + 1;
        launch = 0;
        drop   = 0;
        if (m_held) begin
            if (m_op > 6) drop = 1;
            else if (t >= m_free[m_op]) launch = 1;
        end
        exp_ready = !m_held || launch;
        chk("in_ready", in_ready, exp_ready);
        if (launch) begin
            int dt;
            m_cnt = (m_cnt + 1) % 256;
            q_iss.push_back('{t, m_op, m_rs1, m_rs2, m_cnt});
            dt = t + lat(m_op) - 1;
            if (done_map.exists(dt)) done_map[dt] = done_map[dt] | 7'(1 << m_op);
            else done_map[dt] = 7'(1 << m_op);
            m_free[m_op] = t + lat(m_op);
            m_held = 0;
        end else if (drop) begin
            q_err.push_back(t);
            m_held = 0;
        end
        acc = v && exp_ready;
        if (acc) begin
            m_held = 1;
            m_op   = op;
            m_rs1  = a % (1 << DATA);
            m_rs2  = b % (1 << DATA);
        end
    endtask

    task automatic offer(input int op, input int a, input int b);
        bit acc = 0;
        for (int i = 0; i < 40 && !acc; i++) step(1, op, a, b, acc);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_fu_issue", fu_issue, 0);
        chk("rst_fu_rs1", fu_rs1, 0);
        chk("rst_fu_rs2", fu_rs2, 0);
        chk("rst_fu_done", fu_done, 0);
        chk("rst_err_opcode", err_opcode, 0);
        chk("rst_issue_cnt", issue_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        model_clear();
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            bit       due;
            bit [6:0] exp_done;
            iss_t     e;
            due = (q_iss.size() > 0) && (q_iss[0].t == cyc);
            if (fu_issue != 0 || due) begin
                if (!due) begin
                    chk("issue_unexpected", fu_issue, 0);
                end else begin
                    e = q_iss.pop_front();
                    chk("fu_issue", fu_issue, 1 << e.unit);
                    chk("fu_rs1", fu_rs1, e.rs1);
                    chk("fu_rs2", fu_rs2, e.rs2);
                    chk("issue_cnt", issue_cnt, e.cnt);
                end
            end
            due = (q_err.size() > 0) && (q_err[0] == cyc);
            if (err_opcode || due) begin
                chk("err_opcode", err_opcode, due);
                if (due) void'(q_err.pop_front());
            end
            exp_done = 0;
            if (done_map.exists(cyc)) begin
                exp_done = done_map[cyc];
                done_map.delete(cyc);
            end
            chk("fu_done", fu_done, exp_done);
        end
    end

    initial begin
        bit acc;
        model_clear();
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fu_issue", fu_issue, 0);
        chk("rst_issue_cnt", issue_cnt, 0);
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;

        // ADD, SUB, XOR back to back
        offer(0, 1, 2);
        offer(1, 3, 4);
        offer(4, 5, 6);
        idle(4);
        chk("b2b_issue_cnt", issue_cnt, 3);

        // MUL then MUL
        offer(2, 7, 8);
        offer(2, 9, 10);
        idle(6);

        // DIV, ADD, DIV: second DIV waits for the divider
        offer(3, 11, 12);
        offer(0, 13, 14);
        offer(3, 15, 1);
        idle(8);

        // illegal opcode dropped, next instruction still accepted
        offer(9, 2, 3);
        offer(5, 4, 5);
        idle(4);
        chk("after_err_issue_cnt", issue_cnt, 9);

        // reset with a DIV in flight and a second DIV held
        offer(3, 1, 1);
        offer(3, 2, 2);
        step(0, 0, 0, 0, acc);
        do_reset();
        idle(8);
        chk("post_reset_issue_cnt", issue_cnt, 0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            int op;
            bit v;
            v  = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 6) : $urandom_range(7, 15);
            step(v, op, $urandom_range(0, 15), $urandom_range(0, 15), acc);
        end
        idle(20);
        chk("random_issue_cnt", issue_cnt, m_cnt);

        // 256 issues wrap the counter to zero
        do_reset();
        for (int i = 0; i < 256; i++) offer(i % 7 == 2 ? 0 : 6, i, i + 1);
        idle(4);
        chk("wrap_issue_cnt", issue_cnt, 0);

        idle(8);
        chk("pending_issues", q_iss.size(), 0);
        chk("pending_errs", q_err.size(), 0);
        chk("pending_done", done_map.num(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
